// File: rtl/mmcm_drp_pkg.sv
// mmcm_drp_pkg: FSM states, DRP register map, ClkReg field positions, divide limits and field packing helpers
package mmcm_drp_pkg;
  typedef enum logic [3:0] {
    IDLE, RST_ON, RD1, WT_RD1, WR1, WT_WR1, RD2, WT_RD2, WR2, WT_WR2, RST_OFF, WT_LOCK, DONE
  } state_e;
  localparam logic [6:0] CLK_REG1_ADDR = 7'h08;
  localparam logic [6:0] CLK_REG2_ADDR = 7'h09;
  localparam int FIELD_W = 6;
  localparam int HIGH_LSB = 6;
  localparam int LOW_LSB = 0;
  localparam int EDGE_BIT = 7;
  localparam int NOCOUNT_BIT = 6;
  localparam int DIV_MIN = 1;
  localparam int DIV_MAX = 128;
  function automatic logic [15:0] clk_reg1(input logic [15:0] rd, input logic [7:0] div);
    logic [7:0] high;
    logic [7:0] low;
    logic [15:0] r;
    high = div >> 1;
    low = div - high;
    r = rd;
    r[HIGH_LSB +: FIELD_W] = high[FIELD_W-1:0];
    r[LOW_LSB +: FIELD_W] = low[FIELD_W-1:0];
    return r;
  endfunction
  function automatic logic [15:0] clk_reg2(input logic [15:0] rd, input logic [7:0] div);
    logic [15:0] r;
    r = rd;
    r[EDGE_BIT] = div[0];
    r[NOCOUNT_BIT] = div == 8'd1;
    return r;
  endfunction
endpackage

// File: rtl/mmcm_lock_sync.sv
// mmcm_lock_sync: two-flop synchronizer for the asynchronous MMCM LOCKED signal, clears to 0 on rst
module mmcm_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic locked,
  output logic locked_sync
);
  logic meta;
  always_ff @(posedge clk)
    if (rst) {locked_sync, meta} <= 2'b00;
    else {locked_sync, meta} <= {meta, locked};
endmodule

// File: rtl/mmcm_drp_reconfig_ctrl.sv
// mmcm_drp_reconfig_ctrl: MMCM CLKOUT0 divide reconfiguration via DRP read-modify-write with reset/lock sequencing; define MMCM_DRP_TIMEOUT_EN for DRP/lock wait timeouts
module mmcm_drp_reconfig_ctrl
  import mmcm_drp_pkg::*;
#(
  parameter int DrpTimeoutCycles = 255,
  parameter int LockTimeoutCycles = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic [7:0]  req_div_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  output logic        resp_err_o,
  output logic [6:0]  drp_daddr_o,
  output logic [15:0] drp_di_o,
  input  logic [15:0] drp_do_i,
  output logic        drp_den_o,
  output logic        drp_dwe_o,
  input  logic        drp_drdy_i,
  output logic        mmcm_rst_o,
  input  logic        mmcm_locked_i,
  output logic        clk_en_o
);
  if (DrpTimeoutCycles < 1 || LockTimeoutCycles < 1) begin : g_param_check
    $error("timeout parameters must be at least 1");
  end
  state_e state, state_nxt;
  logic [7:0] div_q;
  logic [15:0] rd_q;
  logic err_q, err_nxt;
  logic locked_sync, ack, tmo, div_ok, in_wt;
  mmcm_lock_sync u_lock_sync (
    .clk(clk_i),
    .rst(rst_i),
    .locked(mmcm_locked_i),
    .locked_sync(locked_sync)
  );
  assign div_ok = req_div_i >= 8'(DIV_MIN) && req_div_i <= 8'(DIV_MAX);
  assign in_wt = state inside {WT_RD1, WT_WR1, WT_RD2, WT_WR2, WT_LOCK};
  assign ack = state == WT_LOCK ? locked_sync : drp_drdy_i;
`ifdef MMCM_DRP_TIMEOUT_EN
  localparam int CntMax = DrpTimeoutCycles > LockTimeoutCycles ? DrpTimeoutCycles : LockTimeoutCycles;
  localparam int CntW = $clog2(CntMax + 1);
  logic [CntW-1:0] wait_cnt;
  always_ff @(posedge clk_i)
    if (rst_i || !in_wt) wait_cnt <= '0;
    else wait_cnt <= wait_cnt + 1'b1;
  assign tmo = in_wt && (state == WT_LOCK ? wait_cnt == CntW'(LockTimeoutCycles - 1)
                                          : wait_cnt == CntW'(DrpTimeoutCycles - 1));
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    err_nxt = err_q;
    case (state)
      IDLE: if (req_valid_i) begin
        state_nxt = div_ok ? RST_ON : DONE;
        err_nxt = !div_ok;
      end
      RST_ON: state_nxt = RD1;
      RD1: state_nxt = WT_RD1;
      WR1: state_nxt = WT_WR1;
      RD2: state_nxt = WT_RD2;
      WR2: state_nxt = WT_WR2;
      RST_OFF: state_nxt = WT_LOCK;
      WT_RD1: if (ack) state_nxt = WR1;
      WT_WR1: if (ack) state_nxt = RD2;
      WT_RD2: if (ack) state_nxt = WR2;
      WT_WR2: if (ack) state_nxt = RST_OFF;
      WT_LOCK: if (ack) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (tmo && !ack) begin
      state_nxt = DONE;
      err_nxt = 1'b1;
    end
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      err_q <= 1'b0;
      div_q <= '0;
      rd_q <= '0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
      if (state == IDLE && req_valid_i) div_q <= req_div_i;
      if ((state == WT_RD1 || state == WT_RD2) && drp_drdy_i) rd_q <= drp_do_i;
    end
  assign req_ready_o = !rst_i && state == IDLE;
  assign resp_valid_o = !rst_i && state == DONE;
  assign resp_err_o = resp_valid_o && err_q;
  assign drp_den_o = !rst_i && state inside {RD1, WR1, RD2, WR2};
  assign drp_dwe_o = !rst_i && state inside {WR1, WR2};
  assign mmcm_rst_o = !rst_i && state inside {RST_ON, RD1, WT_RD1, WR1, WT_WR1, RD2, WT_RD2, WR2, WT_WR2};
  assign clk_en_o = rst_i || state inside {IDLE, DONE};
  assign drp_daddr_o = rst_i ? '0
                     : state inside {RD1, WT_RD1, WR1, WT_WR1} ? CLK_REG1_ADDR
                     : state inside {RD2, WT_RD2, WR2, WT_WR2} ? CLK_REG2_ADDR : '0;
  assign drp_di_o = rst_i ? '0
                  : state inside {WR1, WT_WR1} ? clk_reg1(rd_q, div_q)
                  : state inside {WR2, WT_WR2} ? clk_reg2(rd_q, div_q) : '0;
endmodule

// File: tb/tb_mmcm_drp_reconfig_ctrl.sv
// tb_mmcm_drp_reconfig_ctrl: randomized directed bench with DRP register-file and MMCM lock models
module tb_mmcm_drp_reconfig_ctrl;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic req_valid_i = 1'b0;
  logic [7:0] req_div_i = '0;
  logic req_ready_o, resp_valid_o, resp_err_o;
  logic [6:0] drp_daddr_o;
  logic [15:0] drp_di_o;
  logic [15:0] drp_do_i = '0;
  logic drp_den_o, drp_dwe_o;
  logic drp_drdy_i = 1'b0;
  logic mmcm_rst_o, clk_en_o;
  logic mmcm_locked_i = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [15:0] mem [128];
  logic [6:0] wr_addr_q [$];
  logic [15:0] wr_data_q [$];
  int den_count = 0;
  int resp_count = 0;
  int lock_delay = 20;
  int lock_cnt = 0;
  int lat_left = 0;
  bit drdy_mute = 0;
  bit busy = 0;
  bit rst_seen = 0;
  bit cur_we;
  logic [6:0] cur_addr;
  logic [15:0] cur_di;
  always #5 clk_i = ~clk_i;
  mmcm_drp_reconfig_ctrl dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_valid_i(req_valid_i),
    .req_div_i(req_div_i),
    .req_ready_o(req_ready_o),
    .resp_valid_o(resp_valid_o),
    .resp_err_o(resp_err_o),
    .drp_daddr_o(drp_daddr_o),
    .drp_di_o(drp_di_o),
    .drp_do_i(drp_do_i),
    .drp_den_o(drp_den_o),
    .drp_dwe_o(drp_dwe_o),
    .drp_drdy_i(drp_drdy_i),
    .mmcm_rst_o(mmcm_rst_o),
    .mmcm_locked_i(mmcm_locked_i),
    .clk_en_o(clk_en_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] exp_reg1(input int div, input logic [15:0] rd);
    int high;
    int low;
    high = div / 2;
    low = div - high;
    return (rd & 16'hF000) | 16'((high % 64) * 64 + (low % 64));
  endfunction
  function automatic logic [15:0] exp_reg2(input int div, input logic [15:0] rd);
    return (rd & 16'hFF3F) | 16'((div % 2) * 128 + (div == 1 ? 64 : 0));
  endfunction
  always @(negedge clk_i) begin
    drp_drdy_i = 1'b0;
    drp_do_i = 16'($urandom);
    if (rst_i) busy = 0;
    else if (busy) begin
      chk("drp_stable", {drp_den_o, drp_daddr_o, drp_di_o}, {1'b0, cur_addr, cur_di});
      if (lat_left == 0) begin
        drp_drdy_i = 1'b1;
        busy = 0;
        if (cur_we) begin
          mem[cur_addr] = cur_di;
          wr_addr_q.push_back(cur_addr);
          wr_data_q.push_back(cur_di);
        end else drp_do_i = mem[cur_addr];
      end else lat_left--;
    end
    if (!rst_i && drp_den_o) begin
      den_count++;
      if (!drdy_mute) begin
        busy = 1;
        lat_left = $urandom_range(3);
        cur_addr = drp_daddr_o;
        cur_we = drp_dwe_o;
        cur_di = drp_di_o;
      end
    end
  end
  always @(negedge clk_i) begin
    if (mmcm_rst_o) begin
      mmcm_locked_i = 1'b0;
      lock_cnt = 0;
    end else if (!mmcm_locked_i) begin
      lock_cnt++;
      if (lock_cnt >= lock_delay) mmcm_locked_i = 1'b1;
    end
  end
  always @(negedge clk_i)
    if (!rst_i) begin
      chk("rst_clken_excl", mmcm_rst_o & clk_en_o, 0);
      chk("ready_excl", req_ready_o & (mmcm_rst_o | resp_valid_o | drp_den_o), 0);
      if (resp_valid_o) resp_count++;
      if (mmcm_rst_o) rst_seen = 1;
    end
  initial begin
    #900000;
    $display("FAIL watchdog run_not_finished");
    $fatal(1, "watchdog expired");
  end
  task automatic run_req(input int div, input logic [15:0] r1, input logic [15:0] r2);
    bit ok = div >= 1 && div <= 128;
    int base = den_count;
    int resps = resp_count;
    int n = 0;
    mem[8] = r1;
    mem[9] = r2;
    wr_addr_q.delete();
    wr_data_q.delete();
    rst_seen = 0;
    req_valid_i = 1'b1;
    req_div_i = 8'(div);
    chk("req_ready", req_ready_o, 1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    if (ok) chk("start_outs", {resp_valid_o, mmcm_rst_o, clk_en_o}, 3'b010);
    else chk("inv_next_cycle", {resp_valid_o, resp_err_o, mmcm_rst_o, clk_en_o}, 4'b1101);
    while (!resp_valid_o && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    chk("resp_valid", resp_valid_o, 1);
    chk("resp_err", resp_err_o, !ok);
    chk("done_outs", {mmcm_rst_o, clk_en_o}, 2'b01);
    if (ok) begin
      chk("locked_at_done", mmcm_locked_i, 1);
      chk("den_count", den_count - base, 4);
      chk("wr_count", wr_addr_q.size(), 2);
      if (wr_addr_q.size() == 2) begin
        chk("wr1_addr", wr_addr_q[0], 8);
        chk("wr1_data", wr_data_q[0], exp_reg1(div, r1));
        chk("wr2_addr", wr_addr_q[1], 9);
        chk("wr2_data", wr_data_q[1], exp_reg2(div, r2));
      end
    end else begin
      chk("inv_no_den", den_count - base, 0);
      chk("inv_no_mmcm_rst", rst_seen, 0);
    end
    @(negedge clk_i);
    chk("after_done", {resp_valid_o, req_ready_o}, 2'b01);
    chk("one_resp", resp_count - resps, 1);
  endtask
  initial begin
    int d;
    int n;
    int base;
    int resps;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] e1;
    logic [15:0] e2;
    for (int a = 0; a < 128; a++) mem[a] = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_outs", {resp_valid_o, resp_err_o, drp_den_o, drp_dwe_o, mmcm_rst_o, clk_en_o}, 6'b000001);
    chk("rst_drp_bus", {drp_daddr_o, drp_di_o}, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("ready_after_rst", req_ready_o, 1);
    lock_delay = 20;
    run_req(10, 16'hF000, 16'h1234);
    run_req(1, 16'h0000, 16'h0000);
    run_req(0, 16'hAAAA, 16'h5555);
    run_req(200, 16'hAAAA, 16'h5555);
    run_req(128, 16'h0FFF, 16'hFFFF);
    for (int i = 0; i < 8; i++) begin
      d = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(128, 1));
      lock_delay = $urandom_range(40, 2);
      run_req(d, 16'($urandom), 16'($urandom));
    end
    r1 = 16'($urandom);
    r2 = 16'($urandom);
    mem[8] = r1;
    mem[9] = r2;
    wr_addr_q.delete();
    wr_data_q.delete();
    resps = resp_count;
    req_valid_i = 1'b1;
    req_div_i = 8'd7;
    @(negedge clk_i);
    req_div_i = 8'd12;
    n = 0;
    while (!resp_valid_o && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    chk("b2b_first_resp", {resp_valid_o, req_ready_o}, 2'b10);
    @(negedge clk_i);
    chk("b2b_idle_gap", {req_ready_o, mmcm_rst_o, resp_valid_o}, 3'b100);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("b2b_second_start", {mmcm_rst_o, req_ready_o}, 2'b10);
    n = 0;
    while (!resp_valid_o && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    chk("b2b_second_resp", {resp_valid_o, resp_err_o}, 2'b10);
    e1 = exp_reg1(7, r1);
    e2 = exp_reg2(7, r2);
    chk("b2b_wr_count", wr_addr_q.size(), 4);
    if (wr_addr_q.size() == 4) begin
      chk("b2b_wr_addrs", {wr_addr_q[0], wr_addr_q[1], wr_addr_q[2], wr_addr_q[3]}, {7'h08, 7'h09, 7'h08, 7'h09});
      chk("b2b_wr0", wr_data_q[0], e1);
      chk("b2b_wr1", wr_data_q[1], e2);
      chk("b2b_wr2", wr_data_q[2], exp_reg1(12, e1));
      chk("b2b_wr3", wr_data_q[3], exp_reg2(12, e2));
    end
    @(negedge clk_i);
    chk("b2b_two_resps", resp_count - resps, 2);
    mem[8] = 16'h1111;
    mem[9] = 16'h2222;
    resps = resp_count;
    req_valid_i = 1'b1;
    req_div_i = 8'd37;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    n = 0;
    while (!(drp_den_o && drp_dwe_o && drp_daddr_o == 7'h08) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("saw_wr1", {drp_den_o, drp_dwe_o, drp_daddr_o}, {2'b11, 7'h08});
    @(negedge clk_i);
    chk("in_wt_wr1", {mmcm_rst_o, drp_den_o, drp_daddr_o}, {2'b10, 7'h08});
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("mid_rst_outs", {req_ready_o, resp_valid_o, mmcm_rst_o, clk_en_o, drp_den_o}, 5'b00010);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_ready", {req_ready_o, mmcm_rst_o}, 2'b10);
    repeat (5) @(negedge clk_i);
    chk("mid_rst_no_resp", resp_count - resps, 0);
    chk("mid_rst_stays_idle", req_ready_o, 1);
`ifdef MMCM_DRP_TIMEOUT_EN
    base = den_count;
    drdy_mute = 1;
    req_valid_i = 1'b1;
    req_div_i = 8'd9;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    n = 1;
    while (!resp_valid_o && n < 600) begin
      @(negedge clk_i);
      n++;
    end
    chk("tmo_latency", n, 3 + 255);
    chk("tmo_outs", {resp_valid_o, resp_err_o, mmcm_rst_o, clk_en_o}, 4'b1101);
    chk("tmo_one_den", den_count - base, 1);
    drdy_mute = 0;
    @(negedge clk_i);
    chk("tmo_idle", req_ready_o, 1);
`else
    resps = resp_count;
    drdy_mute = 1;
    req_valid_i = 1'b1;
    req_div_i = 8'd9;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (400) @(negedge clk_i);
    chk("no_tmo_resp", resp_count - resps, 0);
    chk("no_tmo_hold", {mmcm_rst_o, clk_en_o, req_ready_o}, 3'b100);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    drdy_mute = 0;
    @(negedge clk_i);
    chk("no_tmo_recover", {req_ready_o, mmcm_rst_o}, 2'b10);
`endif
    lock_delay = 20;
    run_req(64, 16'h8421, 16'h7EC3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
